// File: rtl/shift_arb_pkg.sv
// Shared constants for the shift arbiter slice.
//   W_DEF   : default operand/result width (matches the shared shifter)
//   CNT_W   : width of the optional per-requester accept counters
//   S_*     : FSM state encoding
//   ptr_inc : modulo-n increment used for the round-robin pointer
package shift_arb_pkg;

  localparam int unsigned W_DEF = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Increment v and wrap to 0 once it reaches n.
  function automatic int unsigned ptr_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this cycle
//   grant : one-hot winner (all zero when nothing is requested)
//   gid   : index of the winner
//   any   : at least one request is pending
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid,
  output logic            any
);

  // Walk from ptr upward modulo NREQ; the first pending request wins.
  always_comb begin
    logic [IDW-1:0] idx;
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external combinational shifter between NREQ requesters.
// One request is accepted at a time (round-robin), its operands are driven
// to the shifter from registers, and the captured result is returned with
// the requester id under response backpressure.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot, IDLE only)
//   req_a, req_b          : packed per-requester operands, slot i at [i*W +: W]
//   sh_a, sh_b, sh_out    : registered operands to / result from the shifter
//   resp_valid/resp_ready : result handshake; resp_id/resp_data held meanwhile
//   busy                  : FSM is not idle
// Optional feature (macro SHIFT_ARB_STATS_EN): stats_clr input and
// grant_cnt output, a 16-bit saturating accept count per requester.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned IDW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [W-1:0]        sh_a,
  output logic [W-1:0]        sh_b,
  input  logic [W-1:0]        sh_out,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [W-1:0]        resp_data,
`ifdef SHIFT_ARB_STATS_EN
  input  logic                stats_clr,
  output logic [NREQ*CNT_W-1:0] grant_cnt,
`endif
  output logic                busy
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic            any;
  logic            accept;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [IDW-1:0]  ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gid   (gid),
    .any   (any)
  );

  // Grant is only offered while idle, so accept implies valid & ready on the winner.
  assign accept    = (state == S_IDLE) && any;
  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign ptr_nxt   = IDW'(ptr_inc(32'(gid), NREQ));

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // State register; busy is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch on accept, result capture in EXEC, release on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sh_a    <= sel_a;
            sh_b    <= sel_b;
            resp_id <= gid;
            rr_ptr  <= ptr_nxt;
          end
        end
        S_EXEC: begin
          resp_data  <= sh_out;
          resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // Per-requester saturating accept counters; clear wins over increment.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (stats_clr) begin
        cnt <= '0;
      end else if (accept && grant[gi] && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule
